// File: rtl/instrumented_adder_sequencer.sv
// instrumented_adder_sequencer
// Measurement sequencer for the instrumented Sklansky adder: latches an
// operand pair, lets the adder settle, enables the ring-oscillator chain for
// a programmed window while counting synchronized ring edges, then captures
// the adder sum and the edge count for logic-analyser readback.
// Optional build macro: INSTR_SEQ_CHECK_EN adds a sum comparator that drives
// mismatch; without it mismatch is tied low.
module instrumented_adder_sequencer #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [CNT_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             ring_en,
  input  logic             ring_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] sum_out,
  output logic [CNT_W-1:0] ring_count,
  output logic             ring_sat,
  output logic             mismatch
);

  // Phase counter covers both the settle interval and the two drain cycles.
  localparam int              PH_W        = $clog2(SETTLE + 2);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0] DRAIN_LAST  = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [PH_W-1:0]  phase;
  logic             ring_p0;
  logic             ring_p1;
  logic             ring_p2;
  logic             ring_rise;
  logic             accept;
  logic             counting;

  // Edge counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign counting  = (state == S_RUN) || (state == S_DRAIN);
  assign ring_rise = ring_p1 & ~ring_p2;

  // Run sequencing: operand latch, settle, ring window, drain, capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ring_en    <= 1'b0;
      adder_a    <= '0;
      adder_b    <= '0;
      sum_out    <= '0;
      ring_count <= '0;
      win_cnt    <= '0;
      phase      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            adder_a <= a_in;
            adder_b <= b_in;
            win_cnt <= (window == '0) ? CNT_W'(1) : window;
            phase   <= SETTLE_LAST;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (phase == '0) begin
            ring_en <= 1'b1;
            state   <= S_RUN;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        S_RUN: begin
          if (win_cnt == CNT_W'(1)) begin
            ring_en <= 1'b0;
            phase   <= DRAIN_LAST;
            state   <= S_DRAIN;
          end else begin
            win_cnt <= win_cnt - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (phase == '0) begin
            state <= S_CAPTURE;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        S_CAPTURE: begin
          sum_out    <= sum_in;
          ring_count <= edge_cnt;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          ring_en <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Ring tap synchronizer plus delay flop; rising edges counted in RUN/DRAIN.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ring_p0  <= 1'b0;
      ring_p1  <= 1'b0;
      ring_p2  <= 1'b0;
      edge_cnt <= '0;
      ring_sat <= 1'b0;
    end else begin
      ring_p0 <= ring_in;
      ring_p1 <= ring_p0;
      ring_p2 <= ring_p1;
      if (accept) begin
        edge_cnt <= '0;
        ring_sat <= 1'b0;
      end else if (counting && ring_rise) begin
        edge_cnt <= sat_inc(edge_cnt);
        if (edge_cnt == CNT_MAX) begin
          ring_sat <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_SEQ_CHECK_EN
  logic [WIDTH-1:0] expect_sum;

  assign expect_sum = adder_a + adder_b;

  // Compare the adder result against the reference sum at capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mismatch <= 1'b0;
    end else if (state == S_CAPTURE) begin
      mismatch <= (sum_in != expect_sum);
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Testbench for instrumented_adder_sequencer: table-driven runs, random runs
// against a behavioural run model, and hand-written handshake/reset/saturation
// sequences. A narrow-counter instance exercises edge-counter saturation.
module tb_instrumented_adder_sequencer;

  localparam int SETTLE = 2;
`ifdef INSTR_SEQ_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in, window;
  logic        ring_in;
  logic [31:0] sum_err;
  logic        busy, done, ring_en, ring_sat, mismatch;
  logic [31:0] adder_a, adder_b, sum_in, sum_out, ring_count;

  logic        start_s;
  logic [7:0]  a_s, b_s;
  logic [0:0]  window_s;
  logic        ring_s;
  logic        busy_s, done_s, ring_en_s, ring_sat_s, mismatch_s;
  logic [7:0]  adder_a_s, adder_b_s, sum_in_s, sum_out_s;
  logic [0:0]  ring_count_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Adder stand-in; sum_err injects a wrong result for the comparator.
  assign sum_in   = adder_a + adder_b + sum_err;
  assign sum_in_s = adder_a_s + adder_b_s;

  instrumented_adder_sequencer #(.WIDTH(32), .CNT_W(32), .SETTLE(SETTLE)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .window(window), .busy(busy), .done(done), .adder_a(adder_a),
    .adder_b(adder_b), .ring_en(ring_en), .ring_in(ring_in), .sum_in(sum_in),
    .sum_out(sum_out), .ring_count(ring_count), .ring_sat(ring_sat),
    .mismatch(mismatch)
  );

  // One-bit counter instance: saturation is reachable within a window.
  instrumented_adder_sequencer #(.WIDTH(8), .CNT_W(1), .SETTLE(SETTLE)) dut_s (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start_s), .a_in(a_s), .b_in(b_s),
    .window(window_s), .busy(busy_s), .done(done_s), .adder_a(adder_a_s),
    .adder_b(adder_b_s), .ring_en(ring_en_s), .ring_in(ring_s),
    .sum_in(sum_in_s), .sum_out(sum_out_s), .ring_count(ring_count_s),
    .ring_sat(ring_sat_s), .mismatch(mismatch_s)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    int          per;
    logic [31:0] err;
    logic [31:0] exp_sum;
    int          exp_lat;
    int          exp_en;
    int          exp_edges;
    bit          exp_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp);
    tests++;
    if ((exp == 0 && act != 0) || act > exp + 1 || act + 1 < exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-1)", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run; ring_in toggles every per/2 clocks while ring_en is high.
  task automatic run(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                     input logic [31:0] tw, input int per, input logic [31:0] terr,
                     input logic [31:0] esum, input int elat, input int een,
                     input int eedge, input bit emis);
    int lat, en_cnt, en_first, ph;
    bit got;
    lat = 0; en_cnt = 0; en_first = -1; ph = 0; got = 1'b0;
    a_in = ta; b_in = tb; window = tw; sum_err = terr; ring_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a_in = ~ta; b_in = $urandom; window = $urandom;
    chk({nm, "_busy_rise"}, busy, 1'b1);
    chk({nm, "_adder_a"}, adder_a, ta);
    chk({nm, "_adder_b"}, adder_b, tb);
    chk({nm, "_sat_clear"}, ring_sat, 1'b0);
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (ring_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        ph++;
        if (per > 0 && (ph % (per / 2)) == 0) ring_in = ~ring_in;
      end
      if (done) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    ring_in = 1'b0;
    chk({nm, "_finished"}, got, 1'b1);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_ring_en_cycles"}, en_cnt, een);
    chk({nm, "_ring_en_start"}, en_first, SETTLE);
    chk({nm, "_sum_out"}, sum_out, esum);
    chk_near({nm, "_ring_count"}, int'(ring_count), eedge);
    chk({nm, "_ring_sat"}, ring_sat, 1'b0);
    chk({nm, "_mismatch"}, mismatch, CHECK_ON && emis);
    chk({nm, "_busy_fall"}, busy, 1'b0);
    chk({nm, "_adder_a_hold"}, adder_a, ta);
    tick();
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int dones, first, seen, k2, per, weff;
    logic [31:0] ra, rb, rw, re;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'd10, 0, 32'd0, 32'h0000_0008, 15, 10, 0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 32'd0,  0, 32'd0, 32'h0000_0000, 6,  1,  0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd1,  0, 32'd1, 32'h0000_0001, 6,  1,  0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd1,  0, 32'd0, 32'h0000_0000, 6,  1,  0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'd64, 8, 32'd0, 32'h2345_6789, 69, 64, 8, 1'b0};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5B, 32'd7,  4, 32'd0, 32'h0000_0000, 12, 7,  2, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'd20, 2, 32'd0, 32'h0000_0000, 25, 20, 10, 1'b0};

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; window = '0;
    ring_in = 1'b0; sum_err = '0;
    start_s = 1'b0; a_s = '0; b_s = '0; window_s = '0; ring_s = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ring_en", ring_en, 1'b0);
    chk("reset_sum_out", sum_out, 32'h0);
    chk("reset_ring_count", ring_count, 32'h0);
    chk("reset_adder_a", adder_a, 32'h0);
    chk("reset_mismatch", mismatch, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].per,
          vecs[i].err, vecs[i].exp_sum, vecs[i].exp_lat, vecs[i].exp_en,
          vecs[i].exp_edges, vecs[i].exp_mis);
    end

    // Random runs against the run model: latency, window, sum, edge count.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rw = 32'($urandom_range(0, 30));
      per = 2 * $urandom_range(0, 4);
      re = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      weff = (rw == 0) ? 1 : int'(rw);
      run($sformatf("rnd%0d", i), ra, rb, rw, per, re, ra + rb + re,
          SETTLE + weff + 3, weff,
          (per == 0) ? 0 : ((weff / (per / 2)) + 1) / 2, re != 32'd0);
    end

    // Reset in the middle of a long window.
    run("pre_rst", 32'd5, 32'd3, 32'd2, 0, 32'd0, 32'd8, 7, 2, 0, 1'b0);
    a_in = 32'd1; b_in = 32'd2; window = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("rst_mid_ring_en", ring_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ring_en", ring_en, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_done", done, 1'b0);
    chk("rst_async_sum_out", sum_out, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (busy || done || ring_en) seen++;
    end
    chk("rst_run_discarded", seen, 0);
    chk("rst_sum_out_after", sum_out, 32'h0);

    // start held high: done, one idle cycle, next run.
    a_in = 32'd7; b_in = 32'd9; window = 32'd4; sum_err = '0; start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done) break;
    end
    chk("hs_done", done, 1'b1);
    chk("hs_idle_busy", busy, 1'b0);
    tick();
    chk("hs_rerun_busy", busy, 1'b1);
    chk("hs_rerun_done", done, 1'b0);
    start = 1'b0;
    k2 = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) begin
        k2 = k;
        break;
      end
    end
    chk("hs_second_latency", k2, 9);
    chk("hs_second_sum", sum_out, 32'd16);
    tick();

    // A start pulse during RUN is ignored.
    a_in = 32'd100; b_in = 32'd23; window = 32'd10; start = 1'b1;
    tick();
    start = 1'b0; a_in = 32'd5; b_in = 32'd5;
    dones = 0; first = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = (k == 5);
      if (done) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    start = 1'b0;
    chk("ign_done_count", dones, 1);
    chk("ign_latency", first, 15);
    chk("ign_sum", sum_out, 32'd123);
    chk("ign_busy", busy, 1'b0);

    // Saturation on the one-bit counter: two edges in the window.
    a_s = 8'hF0; b_s = 8'h20; window_s = 1'b0; ring_s = 1'b0; start_s = 1'b1;
    tick();
    start_s = 1'b0; ring_s = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ring_s = ~ring_s;
      if (k == 5) chk("sat_done_early", done_s, 1'b0);
    end
    chk("sat_done_at_6", done_s, 1'b1);
    chk("sat_ring_count", ring_count_s, 1'b1);
    chk("sat_ring_sat", ring_sat_s, 1'b1);
    chk("sat_sum_out", sum_out_s, 8'h10);
    ring_s = 1'b0;
    repeat (4) tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("sat_cleared_on_start", ring_sat_s, 1'b0);
    repeat (6) tick();
    chk("sat_quiet_done", done_s, 1'b1);
    chk("sat_quiet_count", ring_count_s, 1'b0);
    chk("sat_quiet_sat", ring_sat_s, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_sequencer.md
# instrumented_adder_sequencer

Measurement sequencer for the instrumented Sklansky adder. It latches a pair of operands and presents them to the adder, lets them settle, then enables the adder's ring-oscillator chain for a programmed number of clock cycles while counting synchronized ring edges. At the end it captures the adder sum and the edge count for readback over the logic analyser interface. It sits between the LA-facing register logic and the adder datapath inside the wrapped project.

## Interface

- WIDTH, 32, operand/sum width
- CNT_W, 32, width of window and ring-edge counters
- SETTLE, 2, operand settle cycles before ring enable (≥1)

- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a run; sampled only in IDLE
- a_in  in  WIDTH  operand A, sampled with accepted start
- b_in  in  WIDTH  operand B, sampled with accepted start
- window  in  CNT_W  ring-enable duration in clocks, sampled with start; 0 treated as 1
- busy  out  1  high from start acceptance until capture
- done  out  1  one-cycle pulse at capture
- adder_a  out  WIDTH  registered operand A to adder
- adder_b  out  WIDTH  registered operand B to adder
- ring_en  out  1  ring-oscillator chain enable, registered
- ring_in  in  1  ring-oscillator tap, asynchronous to wb_clk_i
- sum_in  in  WIDTH  adder sum
- sum_out  out  WIDTH  captured sum
- ring_count  out  CNT_W  captured rising-edge count of ring_in
- ring_sat  out  1  edge counter saturated during last run
- mismatch  out  1  captured sum ≠ a+b (see Configuration)

## Operation

- Reset (async assert, sync release): all outputs 0, state IDLE, counters cleared. Reset mid-run drops ring_en immediately and discards the run.
- FSM: IDLE → LOAD → RUN → DRAIN → CAPTURE → IDLE.
- IDLE: start=1 → latch a_in/b_in into adder_a/adder_b, load window (0→1), clear edge counter and ring_sat, busy=1, go LOAD.
- LOAD: SETTLE cycles, ring_en=0, then RUN.
- RUN: ring_en=1 for exactly window cycles (down-counter), then DRAIN.
- DRAIN: 2 cycles, ring_en=0; edges still in the synchronizer are counted.
- CAPTURE: sum_out←sum_in, ring_count←edge counter, done=1 for one cycle, busy=0, return to IDLE.
- Edge detection: ring_in through a 2-flop synchronizer plus a delay flop; rising edge = sync & ~delayed. Counted only in RUN and DRAIN.
- Edge counter saturates at 2^CNT_W−1. Any edge arriving while saturated sets ring_sat, which stays set until the next accepted start.
- start in any non-IDLE state is ignored (no queueing). a_in, b_in and window changes after acceptance have no effect.
- adder_a/adder_b hold their values after capture until the next accepted start.

## Timing

- Start sampled at edge E0: busy, adder_a and adder_b valid after E0.
- ring_en rises after edge E0+SETTLE and is high for exactly window clocks.
- done=1, busy=0, and sum_out/ring_count valid after edge E0+SETTLE+window+3.
- Total latency: SETTLE+window+3 cycles.
- The cycle after done is IDLE. start may be asserted in that cycle, so back-to-back runs have one idle cycle between busy periods.
- Ring edges faster than wb_clk_i/2 are undercounted. This is expected, and the counter never counts more edges than occurred.

## Configuration

- INSTR_SEQ_CHECK_EN defined: CAPTURE compares sum_in against (adder_a+adder_b) mod 2^WIDTH and registers mismatch with done. mismatch holds until the next capture and is cleared by reset.
- Undefined: no comparator is built and mismatch is tied 0.

## Test plan

- Reset: assert wb_rst_n=0 mid-RUN with window=100 → ring_en, busy and done drop to 0 immediately. After release, state is IDLE and sum_out=0.
- Basic run: a_in=0x0000_0005, b_in=0x0000_0003, window=10, SETTLE=2, model sum_in=a+b → done exactly 15 cycles after the start edge, sum_out=0x8, ring_en high for exactly 10 cycles, mismatch=0.
- Edge count: ring_in toggled at wb_clk_i/8 during RUN, window=64 → ring_count=8±1. Holding ring_in constant → ring_count=0.
- Boundaries: window=0 → ring_en high for 1 cycle and done at E0+6. With CNT_W=4 and 20 edges → ring_count=15 and ring_sat=1; the next start clears ring_sat.
- Handshake: start held high continuously → done pulses, one idle cycle, next run begins. A second start pulse during RUN is ignored and produces a single done.
- Check (INSTR_SEQ_CHECK_EN defined): a=0xFFFF_FFFF, b=1, model returns 0x1 → mismatch=1. With correct sum 0x0 → mismatch=0.
